// File: rtl/st_drain_pkg.sv
// Shared types for the store-drain controller: the fence FSM state encoding.
package st_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } st_drain_state_e;

endpackage

// File: rtl/st_drain_if.sv
// Requester/memory signal bundle around st_drain_ctrl.
// The master side drives requests, acks and memory grant; the slave side is the controller.
// Handshake: a transfer happens in a cycle where mem_req and mem_gnt are both high;
// st_gnt/ld_gnt mark which requester owned that transfer.
interface st_drain_if;
  logic st_req;
  logic st_gnt;
  logic st_ack;
  logic ld_req;
  logic ld_nonidem;
  logic ld_gnt;
  logic fence;
  logic fence_done;
  logic mem_req;
  logic mem_we;
  logic mem_gnt;

  modport master (
    output st_req, st_ack, ld_req, ld_nonidem, fence, mem_gnt,
    input  st_gnt, ld_gnt, fence_done, mem_req, mem_we
  );

  modport slave (
    input  st_req, st_ack, ld_req, ld_nonidem, fence, mem_gnt,
    output st_gnt, ld_gnt, fence_done, mem_req, mem_we
  );
endinterface

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter between a load and a store requester.
// The pointer moves only on a completed transfer and then favours the loser.
module rr_arb_2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_ld,
  input  logic req_st,
  input  logic advance,
  output logic sel_st
);

  logic fav_st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fav_st <= 1'b0;
    end else if (advance) begin
      fav_st <= !sel_st;
    end
  end

  assign sel_st = req_st && (!req_ld || fav_st);

endmodule

// File: rtl/st_drain_ctrl.sv
// Store/load memory-port controller with outstanding-store tracking and fence drain.
// Optional build macro ST_DRAIN_STALL_CNT_EN adds a saturating stall counter output.
module st_drain_ctrl
  import st_drain_pkg::*;
#(
  parameter int MaxOutstandingStores = 7,
  parameter int CntWidth             = $clog2(MaxOutstandingStores + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_req_i,
  output logic                st_gnt_o,
  input  logic                st_ack_i,
  input  logic                ld_req_i,
  input  logic                ld_nonidem_i,
  output logic                ld_gnt_o,
  input  logic                fence_i,
  output logic                fence_done_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  input  logic                mem_gnt_i,
  output logic [CntWidth-1:0] outst_cnt_o,
`ifdef ST_DRAIN_STALL_CNT_EN
  output logic [31:0]         stall_cnt_o,
`endif
  output logic                err_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstandingStores);

  st_drain_state_e state, state_next;
  logic [CntWidth-1:0] cnt;
  logic err;
  logic st_elig, ld_elig, sel_st, xfer;

  assign st_elig = st_req_i && (cnt < CntMax) && (state == ST_IDLE);
  assign ld_elig = ld_req_i && (!ld_nonidem_i || (cnt == '0));

  rr_arb_2 u_arb (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .req_ld  (ld_elig),
    .req_st  (st_elig),
    .advance (xfer),
    .sel_st  (sel_st)
  );

  assign mem_req_o = st_elig || ld_elig;
  assign mem_we_o  = mem_req_o && sel_st;
  assign xfer      = mem_req_o && mem_gnt_i;
  assign st_gnt_o  = xfer && sel_st;
  assign ld_gnt_o  = xfer && !sel_st;

  // A grant and an ack in the same cycle cancel; an ack with nothing outstanding is an error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      if (st_ack_i && (cnt == '0)) begin
        err <= 1'b1;
      end
      if (st_gnt_o && !st_ack_i) begin
        cnt <= cnt + CntWidth'(1);
      end else if (!st_gnt_o && st_ack_i && (cnt != '0)) begin
        cnt <= cnt - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    fence_done_o = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (fence_i) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cnt == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        fence_done_o = 1'b1;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef ST_DRAIN_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic        stalled;

  assign stalled = (st_req_i && !st_elig) || (ld_req_i && !ld_elig);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`endif

  assign outst_cnt_o = cnt;
  assign err_o       = err;

endmodule

// File: tb/tb_st_drain_ctrl.sv
// Scoreboard bench for st_drain_ctrl: directed scenarios followed by random traffic,
// every cycle checked against a transaction-level model of the controller.
module tb_st_drain_ctrl;

  localparam int MAX = 7;
  localparam int CW  = $clog2(MAX + 1);
`ifdef ST_DRAIN_STALL_CNT_EN
  localparam int EW = 6 + CW + 32;
`else
  localparam int EW = 6 + CW;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  st_drain_if bus ();
  logic [CW-1:0] outst_cnt;
  logic          err;
`ifdef ST_DRAIN_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  st_drain_ctrl #(.MaxOutstandingStores(MAX)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .st_req_i     (bus.st_req),
    .st_gnt_o     (bus.st_gnt),
    .st_ack_i     (bus.st_ack),
    .ld_req_i     (bus.ld_req),
    .ld_nonidem_i (bus.ld_nonidem),
    .ld_gnt_o     (bus.ld_gnt),
    .fence_i      (bus.fence),
    .fence_done_o (bus.fence_done),
    .mem_req_o    (bus.mem_req),
    .mem_we_o     (bus.mem_we),
    .mem_gnt_i    (bus.mem_gnt),
    .outst_cnt_o  (outst_cnt),
`ifdef ST_DRAIN_STALL_CNT_EN
    .stall_cnt_o  (stall_cnt),
`endif
    .err_o        (err)
  );

  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // Model state: outstanding stores, sticky error, fence phase (0 idle, 1 draining, 2 done),
  // whether the store side currently wins a tie, and the stall count.
  int          m_cnt;
  bit          m_err;
  int          m_phase;
  bit          m_fav_st;
  logic [31:0] m_stall;

  function automatic logic [EW-1:0] pack(bit req, bit we, bit sg, bit lg, bit fd, bit er,
                                         int cnt, logic [31:0] stall);
    logic [EW-1:0] v;
`ifdef ST_DRAIN_STALL_CNT_EN
    v = {req, we, sg, lg, fd, er, CW'(cnt), stall};
`else
    v = {req, we, sg, lg, fd, er, CW'(cnt)};
    if (stall == 32'hDEAD_BEEF) v = ~v;
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_cnt    = 0;
    m_err    = 1'b0;
    m_phase  = 0;
    m_fav_st = 1'b0;
    m_stall  = '0;
  endtask

  task automatic drive(bit sr, bit lr, bit ln, bit ak, bit fe, bit mg);
    bus.st_req     = sr;
    bus.ld_req     = lr;
    bus.ld_nonidem = ln;
    bus.st_ack     = ak;
    bus.fence      = fe;
    bus.mem_gnt    = mg;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    exp_q.push_back('0);
    @(negedge clk);
    exp_q.push_back('0);
    #1 rst_n = 1'b1;
  endtask

  task automatic step(bit sr, bit lr, bit ln, bit ak, bit fe, bit mg);
    bit st_el, ld_el, pick_st, req, sg, lg;
    @(negedge clk);
    drive(sr, lr, ln, ak, fe, mg);
    st_el   = sr && (m_cnt < MAX) && (m_phase == 0);
    ld_el   = lr && (!ln || m_cnt == 0);
    req     = st_el || ld_el;
    pick_st = st_el && (!ld_el || m_fav_st);
    sg      = req && mg && pick_st;
    lg      = req && mg && !pick_st;
    exp_q.push_back(pack(req, req && pick_st, sg, lg, m_phase == 2, m_err, m_cnt, m_stall));
    // Advance the model to its post-edge state.
    if (sg || lg) m_fav_st = lg;
    if ((sr && !st_el) || (lr && !ld_el)) begin
      if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    end
    case (m_phase)
      0: if (fe) m_phase = 1;
      1: if (m_cnt == 0) m_phase = 2;
      default: m_phase = 0;
    endcase
    if (ak && m_cnt == 0) m_err = 1'b1;
    if (sg && !ak) m_cnt = m_cnt + 1;
    else if (!sg && ak && m_cnt > 0) m_cnt = m_cnt - 1;
  endtask

  // Monitor: every cycle the DUT presents a full output set, compared mid-low-phase.
  always @(negedge clk) begin
    logic [EW-1:0] act, exp_v;
    #3;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
`ifdef ST_DRAIN_STALL_CNT_EN
      act = {bus.mem_req, bus.mem_we, bus.st_gnt, bus.ld_gnt, bus.fence_done, err, outst_cnt,
             stall_cnt};
`else
      act = {bus.mem_req, bus.mem_we, bus.st_gnt, bus.ld_gnt, bus.fence_done, err, outst_cnt};
`endif
      tests++;
      if (act !== exp_v) begin
        fails++;
        $display("FAIL outputs @%0t {req,we,sgnt,lgnt,fdone,err,cnt..}: got %b expected %b",
                 $time, act, exp_v);
      end
    end
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    do_reset();

    // Fill to the outstanding limit; the 8th store waits until an ack frees a slot.
    repeat (7) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 1, 0, 0);

    // Count 3: non-idempotent load held off until all stores acked.
    repeat (3) step(0, 1, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0, 1);

    // Round-robin from reset: load, store, load, store.
    do_reset();
    repeat (4) step(1, 1, 0, 0, 0, 1);

    // Count 2: fence drains, stores blocked, done pulse, then idle again.
    step(0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    // Fence at count 0.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Grant and ack together at count 4, then ack at count 0.
    repeat (4) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 1);
    repeat (4) step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Reset while draining with 5 outstanding.
    do_reset();
    repeat (5) step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      bit ak;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        ak = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
        step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
             ak, $urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0);
      end
    end

    @(negedge clk);
    #5;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/st_drain_ctrl.md
ST_DRAIN_CTRL -- requirements
Module: st_drain_ctrl

Interface
REQ-001 SHALL have parameter MaxOutstandingStores, default 7, max stores issued but not acknowledged.
REQ-002 SHALL have parameter CntWidth, default $clog2(MaxOutstandingStores+1), outstanding-counter width.
REQ-003 SHALL have port clk_i input 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni input 1, asynchronous active-low reset.
REQ-005 SHALL have port st_req_i input 1, store requester valid.
REQ-006 SHALL have port st_gnt_o output 1, store forwarded to memory this cycle.
REQ-007 SHALL have port st_ack_i input 1, memory acknowledges one store.
REQ-008 SHALL have port ld_req_i input 1, load requester valid.
REQ-009 SHALL have port ld_nonidem_i input 1, load targets a non-idempotent region; qualified by ld_req_i.
REQ-010 SHALL have port ld_gnt_o output 1, load forwarded to memory this cycle.
REQ-011 SHALL have port fence_i input 1, single-cycle pulse requesting store drain.
REQ-012 SHALL have port fence_done_o output 1, single-cycle pulse: drain complete.
REQ-013 SHALL have port mem_req_o output 1, memory port valid.
REQ-014 SHALL have port mem_we_o output 1, 1 = store, 0 = load; valid with mem_req_o.
REQ-015 SHALL have port mem_gnt_i input 1, memory port accepts the request.
REQ-016 SHALL have port outst_cnt_o output CntWidth, outstanding store count.
REQ-017 SHALL have port err_o output 1, sticky: ack received with count 0.

Function
REQ-018 Store eligible SHALL be: st_req_i and count < MaxOutstandingStores and state = IDLE.
REQ-019 Load eligible SHALL be: ld_req_i and (not ld_nonidem_i or count = 0).
REQ-020 When both eligible, selection SHALL be round-robin; priority pointer flips only on a granted transfer; reset pointer favours loads.
REQ-021 mem_req_o SHALL be high whenever any requester is eligible; mem_we_o SHALL reflect the selected requester; selection SHALL remain stable while mem_gnt_i is low and eligibility is unchanged.
REQ-022 st_gnt_o/ld_gnt_o SHALL equal mem_gnt_i AND mem_req_o AND the respective selection; zero added latency.
REQ-023 Count SHALL increment on st_gnt_o, decrement on st_ack_i; both in the same cycle leave it unchanged.
REQ-024 st_ack_i at count 0 SHALL leave the count at 0 and set err_o until reset.
REQ-025 Count SHALL never exceed MaxOutstandingStores; no wrap-around.
REQ-026 FSM states: IDLE, DRAIN, DONE.
REQ-027 IDLE -> DRAIN on fence_i; fence_i in DRAIN or DONE SHALL be ignored.
REQ-028 DRAIN -> DONE when count = 0 (including the first cycle after fence_i if already 0); stores blocked in DRAIN.
REQ-029 DONE SHALL assert fence_done_o for exactly one cycle, then -> IDLE.
REQ-030 Loads SHALL remain eligible in all states per REQ-019.

Reset
REQ-031 On rst_ni low, asynchronously: count = 0, err_o = 0, state = IDLE, RR pointer = load, fence_done_o = 0; st_gnt_o, ld_gnt_o, mem_req_o low.
REQ-032 Reset mid-DRAIN SHALL abandon the fence with no fence_done_o pulse.

Configuration
REQ-033 Macro ST_DRAIN_STALL_CNT_EN, when defined, SHALL add output stall_cnt_o (32 bits): increments each cycle a request is pending but not eligible; saturates at all-ones; reset to 0.
REQ-034 Without ST_DRAIN_STALL_CNT_EN, the port and counter SHALL be absent; other behaviour identical.

Structure
REQ-035 FSM state enum type st_drain_state_e SHALL live in shared package st_drain_pkg.
REQ-036 Two-way round-robin selection SHALL be a sub-module rr_arb_2.

Verification
REQ-037 Issue 7 stores, no acks -> count 7, 8th st_req_i gets no st_gnt_o; one ack -> next store granted.
REQ-038 Count 3, ld_req_i with ld_nonidem_i = 1 -> ld_gnt_o held low until 3 acks, granted in the cycle count reads 0.
REQ-039 Both eligible, mem_gnt_i = 1 for 4 cycles -> grants alternate load, store, load, store.
REQ-040 Count 2, fence_i -> DRAIN, stores blocked; after 2 acks one-cycle fence_done_o, IDLE next cycle; fence_i at count 0 -> fence_done_o two cycles later.
REQ-041 Grant and ack in the same cycle at count 4 -> count stays 4; ack at count 0 -> err_o = 1 and count stays 0.
REQ-042 rst_ni low during DRAIN with count 5 -> count 0, IDLE, no fence_done_o.
